// File: rtl/m_store_buffer.sv
// m_store_buffer: FIFO write buffer between the M-stage register and data memory, draining one store per cycle.
// Optional macro STB_FWD_EN forwards a load from the youngest same-word entry when that entry is a full-word store.
module m_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [31:0]              st_data,
    input  logic [2:0]               st_sel,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_stall,
    output logic                     ld_fwd_valid,
    output logic [31:0]              ld_fwd_data,
    output logic                     dm_we,
    output logic [AW-1:0]            dm_addr,
    output logic [31:0]              dm_wdata,
    output logic [2:0]               dm_sel,
    input  logic                     dm_ready,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [2:0]    sel_q  [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] idx;
    logic          push;
    logic          pop;
    logic          any_match;
    logic          fwd_hit;
    logic          ld_addr_unused;

`ifdef STB_FWD_EN
    logic          young_word;
    logic [31:0]   young_data;
`endif

    assign empty    = (count == '0);
    assign st_ready = (count < FULL);
    assign push     = st_valid && st_ready;
    assign dm_we    = !empty;
    assign pop      = dm_we && dm_ready;

    // Head outputs come straight from storage; forced to zero while nothing is pending.
    assign dm_addr  = empty ? '0    : addr_q[rd_ptr];
    assign dm_wdata = empty ? 32'd0 : data_q[rd_ptr];
    assign dm_sel   = empty ? 3'd0  : sel_q[rd_ptr];

    // Byte offset within a word never matters for the conflict check.
    assign ld_addr_unused = ^ld_addr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= st_addr;
            data_q[wr_ptr] <= st_data;
            sel_q[wr_ptr]  <= st_sel;
        end
    end

    // Walk entries oldest to youngest so the last hit seen is the youngest match.
    always_comb begin
        any_match = 1'b0;
        idx       = '0;
`ifdef STB_FWD_EN
        young_word = 1'b0;
        young_data = 32'd0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (addr_q[idx][AW-1:2] == ld_addr[AW-1:2])) begin
                any_match = 1'b1;
`ifdef STB_FWD_EN
                young_word = (sel_q[idx] == 3'd0);
                young_data = data_q[idx];
`endif
            end
        end
    end

`ifdef STB_FWD_EN
    assign fwd_hit      = any_match && young_word;
    assign ld_fwd_valid = ld_valid && !st_valid && fwd_hit;
    assign ld_fwd_data  = ld_fwd_valid ? young_data : 32'd0;
`else
    assign fwd_hit      = 1'b0;
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = 32'd0;
`endif

    // A load arriving together with a store is illegal; hold it rather than guess.
    assign ld_stall = ld_valid && (st_valid || (any_match && !fwd_hit));

endmodule

// File: tb/tb_m_store_buffer.sv
// tb_m_store_buffer: directed sequences, a vector table and randomized traffic checked against a queue model.
module tb_m_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic [2:0]  st_sel;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall, ld_fwd_valid;
    logic [31:0] ld_fwd_data;
    logic        dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [2:0]  dm_sel;
    logic        dm_ready;
    logic        empty;
    logic [2:0]  count;

    always #5 clk = ~clk;

    m_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_sel(st_sel),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_sel(dm_sel),
        .dm_ready(dm_ready), .empty(empty), .count(count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  s;
    } ent_t;

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic        dr;
        logic        exp_ready;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [2:0]  exp_count;
    } vec_t;

    ent_t q[$];
    vec_t vecs[11];
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                 input logic [2:0] ss, input logic lv, input logic [31:0] la,
                                 input logic dr);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        st_sel   = ss;
        ld_valid = lv;
        ld_addr  = la;
        dm_ready = dr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic timeoutFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got=timeout want=completion", name);
    endtask

    // Reference: a plain FIFO queue; outputs follow directly from its contents.
    task automatic modelCycle(output logic accepted);
        ent_t y;
        logic hit, fwd, exp_fv, popd;
        int   n;
        #1;
        n   = q.size();
        hit = 1'b0;
        y   = '{a: 32'd0, d: 32'd0, s: 3'd0};
        foreach (q[i])
            if (q[i].a[31:2] == ld_addr[31:2]) begin
                hit = 1'b1;
                y   = q[i];
            end
`ifdef STB_FWD_EN
        fwd = hit && (y.s == 3'd0);
`else
        fwd = 1'b0;
`endif
        exp_fv = ld_valid && !st_valid && fwd;
        checkOutput("mdl st_ready", st_ready, n < DEPTH);
        checkOutput("mdl dm_we", dm_we, n > 0);
        checkOutput("mdl count", count, n);
        checkOutput("mdl empty", empty, n == 0);
        if (n > 0) begin
            checkOutput("mdl dm_addr", dm_addr, q[0].a);
            checkOutput("mdl dm_wdata", dm_wdata, q[0].d);
            checkOutput("mdl dm_sel", dm_sel, q[0].s);
        end else begin
            checkOutput("mdl dm_addr idle", dm_addr, 32'd0);
        end
        checkOutput("mdl ld_stall", ld_stall, ld_valid && (st_valid || (hit && !fwd)));
        checkOutput("mdl fwd_valid", ld_fwd_valid, exp_fv);
        checkOutput("mdl fwd_data", ld_fwd_data, exp_fv ? y.d : 32'd0);
        accepted = st_valid && (n < DEPTH);
        popd     = dm_ready && (n > 0);
        y        = '{a: st_addr, d: st_data, s: st_sel};
        @(posedge clk);
        #1;
        if (popd)
            void'(q.pop_front());
        if (accepted)
            q.push_back(y);
    endtask

    initial begin
        logic acc;
        logic tog;
        int   guard;

        // Reset state
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst dm_we", dm_we, 0);
        checkOutput("rst empty", empty, 1);
        checkOutput("rst st_ready", st_ready, 1);
        checkOutput("rst count", count, 0);
        checkOutput("rst ld_stall", ld_stall, 0);
        checkOutput("rst fwd_valid", ld_fwd_valid, 0);
        checkOutput("rst fwd_data", ld_fwd_data, 0);
        checkOutput("rst dm_addr", dm_addr, 0);
        reset = 1'b0;
        tick();

        // Async reset with three entries queued mid-drain
        applyStimulus(1, 32'h100, 32'h1, 0, 0, 0, 0); tick();
        applyStimulus(1, 32'h104, 32'h2, 0, 0, 0, 0); tick();
        applyStimulus(1, 32'h108, 32'h3, 0, 0, 0, 0); tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        #1;
        checkOutput("mid count3", count, 3);
        checkOutput("mid head", dm_addr, 32'h100);
        tick();
        checkOutput("mid head2", dm_addr, 32'h104);
        reset = 1'b1;
        #1;
        checkOutput("async dm_we", dm_we, 0);
        checkOutput("async count", count, 0);
        checkOutput("async empty", empty, 1);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 32'h10, 32'h11223344, 0, 0, 0, 0);
        #1;
        checkOutput("nopass dm_we", dm_we, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("post dm_we", dm_we, 1);
        checkOutput("post dm_addr", dm_addr, 32'h10);
        checkOutput("post dm_wdata", dm_wdata, 32'h11223344);
        checkOutput("post count", count, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("post empty", empty, 1);

        // Fill with DM blocked, then drain in order
        vecs[0]  = '{1'b1, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0};
        vecs[1]  = '{1'b1, 32'h04, 1'b0, 1'b1, 1'b1, 32'h00, 3'd1};
        vecs[2]  = '{1'b1, 32'h08, 1'b0, 1'b1, 1'b1, 32'h00, 3'd2};
        vecs[3]  = '{1'b1, 32'h0C, 1'b0, 1'b1, 1'b1, 32'h00, 3'd3};
        vecs[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h00, 3'd4};
        vecs[5]  = '{1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h00, 3'd4};
        vecs[6]  = '{1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h04, 3'd3};
        vecs[7]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h08, 3'd3};
        vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h0C, 3'd2};
        vecs[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h10, 3'd1};
        vecs[10] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 3'd0};
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].sv, vecs[i].sa, 32'hD000_0000 | vecs[i].sa, 0, 0, 0, vecs[i].dr);
            #1;
            checkOutput($sformatf("vec%0d st_ready", i), st_ready, vecs[i].exp_ready);
            checkOutput($sformatf("vec%0d dm_we", i), dm_we, vecs[i].exp_we);
            checkOutput($sformatf("vec%0d dm_addr", i), dm_addr, vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d dm_wdata", i), dm_wdata,
                        vecs[i].exp_we ? (32'hD000_0000 | vecs[i].exp_addr) : 32'd0);
            checkOutput($sformatf("vec%0d count", i), count, vecs[i].exp_count);
            tick();
        end

        // Byte store then same-word load
        applyStimulus(1, 32'h23, 32'h123456AB, 3'd2, 0, 0, 0); tick();
        applyStimulus(0, 0, 0, 0, 1, 32'h20, 0);
        #1;
        checkOutput("byte stall1", ld_stall, 1);
        tick();
        checkOutput("byte stall2", ld_stall, 1);
        applyStimulus(0, 0, 0, 0, 1, 32'h20, 1);
        #1;
        checkOutput("byte dm_sel", dm_sel, 2);
        checkOutput("byte dm_addr", dm_addr, 32'h23);
        checkOutput("byte dm_wdata", dm_wdata, 32'h123456AB);
        checkOutput("byte stall head", ld_stall, 1);
        tick();
        checkOutput("byte stall clr", ld_stall, 0);
        checkOutput("byte empty", empty, 1);

        // Different word does not conflict
        applyStimulus(1, 32'h20, 32'h5, 0, 0, 0, 0); tick();
        applyStimulus(0, 0, 0, 0, 1, 32'h24, 0);
        #1;
        checkOutput("diffword stall", ld_stall, 0);
        checkOutput("diffword fwd", ld_fwd_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); tick();

        // Two word stores to the same word, load inside that word
        applyStimulus(1, 32'h40, 32'hAAAA0000, 0, 0, 0, 0); tick();
        applyStimulus(1, 32'h40, 32'hBBBB1111, 0, 0, 0, 0); tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 32'h42, i[0]);
            #1;
`ifdef STB_FWD_EN
            checkOutput("fwd valid", ld_fwd_valid, 1);
            checkOutput("fwd data", ld_fwd_data, 32'hBBBB1111);
            checkOutput("fwd stall", ld_stall, 0);
`else
            checkOutput("nofwd valid", ld_fwd_valid, 0);
            checkOutput("nofwd data", ld_fwd_data, 0);
            checkOutput("nofwd stall", ld_stall, 1);
`endif
            tick();
        end
        applyStimulus(0, 0, 0, 0, 1, 32'h42, 1); tick();
        checkOutput("fwd drained stall", ld_stall, 0);
        checkOutput("fwd drained valid", ld_fwd_valid, 0);
        checkOutput("fwd drained empty", empty, 1);

        // Youngest match is a half store: always stalls
        applyStimulus(1, 32'h40, 32'hCCCC0000, 0, 0, 0, 0); tick();
        applyStimulus(1, 32'h42, 32'h00001234, 3'd1, 0, 0, 0); tick();
        applyStimulus(0, 0, 0, 0, 1, 32'h40, 0);
        #1;
        checkOutput("half stall", ld_stall, 1);
        checkOutput("half fwd", ld_fwd_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); tick(); tick();

        // Store and load together
        applyStimulus(1, 32'h80, 32'h77, 0, 1, 32'h200, 0);
        #1;
        checkOutput("both stall", ld_stall, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("both enq", count, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); tick();
        checkOutput("both empty", empty, 1);

        // Wrap-around with DM ready toggling
        q.delete();
        tog = 1'b1;
        for (int i = 0; i < 10; i++) begin
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 20) begin
                applyStimulus(1, 32'h200 + 32'(i * 4), 32'hA500_0000 + 32'(i), 0, 0, 0, tog);
                modelCycle(acc);
                tog = ~tog;
                guard++;
            end
            if (!acc)
                timeoutFail("wrap accept");
        end
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
            modelCycle(acc);
            guard++;
        end
        if (q.size() > 0)
            timeoutFail("wrap drain");
        checkOutput("wrap empty", empty, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic sv, lv;
            sv = 1'($urandom % 2);
            lv = sv ? 1'b0 : 1'($urandom % 2);
            applyStimulus(sv, 32'($urandom_range(0, 63)), $urandom, 3'($urandom_range(0, 2)),
                          lv, 32'($urandom_range(0, 63)), ($urandom % 10) < 6);
            modelCycle(acc);
        end
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
            modelCycle(acc);
            guard++;
        end
        if (q.size() > 0)
            timeoutFail("rnd drain");
        checkOutput("rnd empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_store_buffer.md
Name: m_store_buffer

Overview:
- Write buffer between the M-stage pipeline register and the data memory.
- Queues up to DEPTH stores (word, half or byte) and drains one per cycle into the DM write port.
- Lets the M stage retire stores without waiting on DM. Stalls any load whose word address matches a pending store.
- DM reads stay combinational and bypass this block.

Parameters:
DEPTH, 4, number of store entries; power of two, at least 2
AW, 32, byte-address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
st_valid  in  1  M stage presents a store
st_ready  out  1  buffer can accept a store this cycle
st_addr  in  AW  store byte address
st_data  in  32  store data; low 16/8 bits used for half/byte
st_sel  in  3  access size: 3'd0 word, 3'd1 half, 3'd2 byte (3..4 are unsigned-load codes, never stored)
ld_valid  in  1  M stage presents a load
ld_addr  in  AW  load byte address
ld_stall  out  1  load must hold this cycle; pending store conflict
ld_fwd_valid  out  1  forwarded load data valid (see Optional Feature)
ld_fwd_data  out  32  forwarded word
dm_we  out  1  DM write enable; head entry valid
dm_addr  out  AW  head entry address
dm_wdata  out  32  head entry data
dm_sel  out  3  head entry size code
dm_ready  in  1  DM accepts the write this cycle
empty  out  1  no pending stores
count  out  log2(DEPTH)+1  number of pending entries

Behaviour:
- Storage: circular FIFO of {addr, data, sel} with rd_ptr, wr_ptr (log2 DEPTH bits, natural wrap) and count.
- Reset (async, immediate): rd_ptr=wr_ptr=0, count=0.
  - Outputs then: dm_we=0, empty=1, st_ready=1, ld_stall=0, ld_fwd_valid=0, ld_fwd_data=0.
  - dm_addr/dm_wdata/dm_sel=0 while empty.
  - Pending stores are discarded.
- st_ready = (count < DEPTH). It is not combinationally dependent on dm_ready; a full buffer refuses even if draining this cycle.
- Enqueue on the clk edge when st_valid && st_ready: entry written at wr_ptr, wr_ptr+1.
- Head: dm_we = !empty; dm_addr/dm_wdata/dm_sel driven from entry rd_ptr (registered storage, no input-to-output path).
- Dequeue on the clk edge when dm_we && dm_ready: rd_ptr+1.
- Latency: a store accepted into an empty buffer appears on dm_* the next cycle. Throughput is 1 store/cycle in and 1/cycle out.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- Empty with enqueue: count 0->1. No pass-through in the same cycle.
- Load conflict check:
  - Compare ld_addr[AW-1:2] against addr[AW-1:2] of every valid entry, including the head being drained this cycle (conservative).
  - ld_stall = ld_valid && any_match && !fwd_hit.
  - Stall clears the cycle after the last matching entry dequeues.
- st_valid and ld_valid together is illegal. If it occurs, the store is enqueued and ld_stall=1.
- Misaligned addresses are stored unchanged. DM owns the alignment rules.
- dm_ready low holds head and count. dm_* outputs stay stable while dm_we=1 and dm_ready=0.

Optional Feature:
STB_FWD_EN:
- Defined:
  - When ld_valid and the youngest matching entry has sel=word, ld_fwd_valid=1 and ld_fwd_data=that entry's data. No stall.
  - If the youngest match is half or byte, stall as normal.
  - The same-word check uses the full address bits [AW-1:2].
- Undefined:
  - ld_fwd_valid=0 and ld_fwd_data=0 constantly.
  - Every conflict stalls.

Test Plan:
- Reset with 3 entries queued mid-drain:
  - Required: dm_we drops to 0 without waiting for clk; count=0; empty=1.
  - Then store 0x10<=0x11223344 word: dm_we=1, dm_addr=0x10, dm_wdata=0x11223344 one cycle later.
- dm_ready=0, 5 word stores to 0x0,0x4,...,0x10 back-to-back:
  - Required: first 4 accepted; st_ready=0 on the 5th; count=4.
  - Raise dm_ready: drains in order 0x0,0x4,0x8,0xC, one per cycle; the 5th is accepted the cycle after count<4.
- Wrap-around: 10 stores with dm_ready toggling 1,0,1,... -> DM sees all 10 in issue order; pointers wrap past 3 correctly; empty=1 at end.
- Byte store 0x23<=0x..AB, then load 0x20 next cycle with dm_ready=0:
  - Required: ld_stall=1 while the entry is pending.
  - dm_ready=1: dm_sel=2, dm_addr=0x23; ld_stall=0 the following cycle.
- Load 0x24 with only an entry to 0x20 pending -> ld_stall=0.
- STB_FWD_EN defined:
  - Word stores 0x40<=0xAAAA0000 then 0x40<=0xBBBB1111 pending; load 0x42.
  - Required: ld_fwd_valid=1, ld_fwd_data=0xBBBB1111, ld_stall=0.
- STB_FWD_EN undefined, same stimulus: ld_stall=1 and ld_fwd_valid=0 until both entries drain.
